// File: rtl/audio_rx.sv
`timescale 1ns / 1ps
// I2S ADC receiver: captures DATA_WIDTH-bit left/right pairs from a codec whose bit clock is asynchronous to clk.
// Defining AUDIO_RX_PEAK_EN adds a peak-magnitude meter (peak_clr / peak_level).
module audio_rx #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  bclk,
    input  logic                  adclrc,
    input  logic                  adcdat,
    output logic [DATA_WIDTH-1:0] left_data,
    output logic [DATA_WIDTH-1:0] right_data,
    output logic                  data_valid,
    input  logic                  data_ack,
    output logic                  frame_err,
`ifdef AUDIO_RX_PEAK_EN
    input  logic                  peak_clr,
    output logic [DATA_WIDTH-2:0] peak_level,
`endif
    output logic                  overrun
);

    // state   | meaning
    // ST_IDLE | out of reset, no previous adclrc sample to compare against
    // ST_HUNT | waiting for an adclrc transition to find a slot boundary
    // ST_RUN  | locked to slot boundaries, counting and shifting bits
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HUNT,
        ST_RUN
    } state_t;

    localparam int CW = $clog2(DATA_WIDTH + 2);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_SAT  = CW'(DATA_WIDTH + 1);

    logic [1:0]            bclk_sync;
    logic [1:0]            lrc_sync;
    logic [1:0]            dat_sync;
    logic                  bclk_prev;
    logic                  bclk_rise;
    logic                  lrc;
    logic                  dat;

    state_t                state;
    logic                  lrc_prev;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_inc;
    logic [DATA_WIDTH-2:0] shift_q;
    logic [DATA_WIDTH-1:0] word;
    logic [DATA_WIDTH-1:0] left_hold;
    logic                  left_seen;

    logic                  lrc_change;
    logic                  word_done;
    logic                  slot_short;
    logic                  pair_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_sync <= '0;
            lrc_sync  <= '0;
            dat_sync  <= '0;
            bclk_prev <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[0], bclk};
            lrc_sync  <= {lrc_sync[0], adclrc};
            dat_sync  <= {dat_sync[0], adcdat};
            bclk_prev <= bclk_sync[1];
        end
    end

    assign bclk_rise = bclk_sync[1] & ~bclk_prev;
    assign lrc       = lrc_sync[1];
    assign dat       = dat_sync[1];

    always_comb begin
        cnt_inc    = (cnt == CNT_SAT) ? cnt : cnt + CNT_ONE;
        word       = {shift_q, dat};
        lrc_change = (lrc != lrc_prev);
        word_done  = bclk_rise && (state == ST_RUN) && !lrc_change && (cnt_inc == CNT_LAST);
        slot_short = bclk_rise && (state == ST_RUN) && lrc_change
                     && (cnt != '0) && (cnt < CNT_LAST);
        pair_done  = word_done && lrc && left_seen;
    end

    // Slot framing: the edge where adclrc flips is the I2S delay bit and carries no data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            lrc_prev  <= 1'b0;
            cnt       <= '0;
            shift_q   <= '0;
            left_hold <= '0;
            left_seen <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= slot_short;
            if (bclk_rise) begin
                lrc_prev <= lrc;
                case (state)
                    ST_IDLE: state <= ST_HUNT;
                    ST_HUNT: begin
                        if (lrc_change) begin
                            state     <= ST_RUN;
                            cnt       <= '0;
                            left_seen <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        if (lrc_change) begin
                            cnt <= '0;
                            if (slot_short)
                                left_seen <= 1'b0;
                        end else begin
                            cnt <= cnt_inc;
                            if (cnt_inc <= CNT_LAST)
                                shift_q <= word[DATA_WIDTH-2:0];
                            if (word_done) begin
                                if (!lrc) begin
                                    left_hold <= word;
                                    left_seen <= 1'b1;
                                end else begin
                                    left_seen <= 1'b0;
                                end
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // A pair landing in the same cycle as data_ack counts as consumed, not overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left_data  <= '0;
            right_data <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (pair_done) begin
                left_data  <= left_hold;
                right_data <= word;
                data_valid <= 1'b1;
                if (data_valid && !data_ack)
                    overrun <= 1'b1;
            end else if (data_ack) begin
                data_valid <= 1'b0;
            end
        end
    end

`ifdef AUDIO_RX_PEAK_EN
    localparam logic [DATA_WIDTH-2:0] MAG_ONE = 1;

    function automatic logic [DATA_WIDTH-2:0] abs_mag(input logic [DATA_WIDTH-1:0] s);
        logic [DATA_WIDTH-2:0] mag;
        if (!s[DATA_WIDTH-1])
            mag = s[DATA_WIDTH-2:0];
        else if (s[DATA_WIDTH-2:0] == '0)
            mag = '1;
        else
            mag = ~s[DATA_WIDTH-2:0] + MAG_ONE;
        return mag;
    endfunction

    logic [DATA_WIDTH-2:0] mag_l;
    logic [DATA_WIDTH-2:0] mag_r;
    logic [DATA_WIDTH-2:0] mag_pair;

    always_comb begin
        mag_l    = abs_mag(left_hold);
        mag_r    = abs_mag(word);
        mag_pair = (mag_l > mag_r) ? mag_l : mag_r;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_level <= '0;
        end else if (pair_done) begin
            if (peak_clr || (mag_pair > peak_level))
                peak_level <= mag_pair;
        end else if (peak_clr) begin
            peak_level <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_audio_rx.sv
`timescale 1ns / 1ps
// Bench for audio_rx: drives I2S frames at bclk = clk/8 with 32-bit slots and scoreboards the captured pairs.
module tb_audio_rx;

    logic        clk;
    logic        rst_n;
    logic        bclk;
    logic        adclrc;
    logic        adcdat;
    logic [15:0] left_data;
    logic [15:0] right_data;
    logic        data_valid;
    logic        data_ack;
    logic        frame_err;
    logic        overrun;
`ifdef AUDIO_RX_PEAK_EN
    logic        peak_clr;
    logic [14:0] peak_level;
`endif

    logic [31:0] sb[$];
    int          nvec;
    int          nerr;
    int          fe_cnt;

    audio_rx #(.DATA_WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bclk       (bclk),
        .adclrc     (adclrc),
        .adcdat     (adcdat),
        .left_data  (left_data),
        .right_data (right_data),
        .data_valid (data_valid),
        .data_ack   (data_ack),
        .frame_err  (frame_err),
`ifdef AUDIO_RX_PEAK_EN
        .peak_clr   (peak_clr),
        .peak_level (peak_level),
`endif
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (frame_err) fe_cnt++;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // All bit tasks start and end on a falling clk edge; one bclk period is 8 clk.
    task automatic send_bit(input logic lrc, input logic d);
        bclk   = 1'b0;
        adclrc = lrc;
        adcdat = d;
        repeat (4) @(negedge clk);
        bclk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_slot(input logic lrc, input logic [15:0] w, input int nbits);
        logic d;
        for (int i = 0; i < nbits; i++) begin
            d = 1'b0;
            if (i >= 1 && i <= 16) d = w[16-i];
            send_bit(lrc, d);
        end
    endtask

    // The last right data bit is driven by hand so its latency and same-cycle ack/clr can be checked.
    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input bit expect_pair,
                              input bit ack_at_done, input bit clr_at_done);
        logic pre_dv;
        logic exp_dv;
        logic d;
        send_slot(1'b0, l, 32);
        for (int i = 0; i < 16; i++) begin
            d = 1'b0;
            if (i >= 1) d = r[16-i];
            send_bit(1'b1, d);
        end
        if (expect_pair) sb.push_back({l, r});
        pre_dv = data_valid;
        exp_dv = expect_pair ? 1'b1 : pre_dv;
        bclk   = 1'b0;
        adcdat = r[0];
        repeat (4) @(negedge clk);
        bclk = 1'b1;
        @(negedge clk);
        @(negedge clk);
        if (!pre_dv) begin
            nvec++;
            if (data_valid !== 1'b0) begin
                nerr++;
                $display("FAIL latency_early: data_valid=%0b required=0", data_valid);
            end
        end
        if (ack_at_done) data_ack = 1'b1;
`ifdef AUDIO_RX_PEAK_EN
        if (clr_at_done) peak_clr = 1'b1;
`else
        if (clr_at_done) $display("note: clr_at_done ignored without peak meter");
`endif
        @(negedge clk);
        data_ack = 1'b0;
`ifdef AUDIO_RX_PEAK_EN
        peak_clr = 1'b0;
`endif
        nvec++;
        if (data_valid !== exp_dv) begin
            nerr++;
            $display("FAIL latency_rise: data_valid=%0b required=%0b", data_valid, exp_dv);
        end
        @(negedge clk);
        for (int i = 17; i < 32; i++) send_bit(1'b1, 1'b0);
    endtask

    task automatic ack_pulse();
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
        nvec++;
        if (data_valid !== 1'b0) begin
            nerr++;
            $display("FAIL ack_clear: data_valid=%0b required=0", data_valid);
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        bclk     = 1'b0;
        adclrc   = 1'b0;
        adcdat   = 1'b0;
        data_ack = 1'b0;
`ifdef AUDIO_RX_PEAK_EN
        peak_clr = 1'b0;
`endif
        repeat (4) @(negedge clk);
        nvec++;
        if ({left_data, right_data, data_valid, frame_err, overrun} !== 35'd0) begin
            nerr++;
            $display("FAIL reset_outputs: left=%h right=%h dv=%0b fe=%0b ovr=%0b required=all 0",
                     left_data, right_data, data_valid, frame_err, overrun);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    endtask

    task automatic test_basic();
        logic [31:0] exp;
        send_frame(16'h1234, 16'hABCD, 1'b1, 1'b0, 1'b0);
        nvec++;
        if (sb.size() == 0) begin
            nerr++;
            $display("FAIL basic_sb: queue empty, required 1 entry");
        end else begin
            exp = sb.pop_front();
            if ({left_data, right_data} !== exp) begin
                nerr++;
                $display("FAIL basic_pair: got %h/%h required %h/%h", left_data, right_data, exp[31:16], exp[15:0]);
            end
        end
        nvec++;
        if (data_valid !== 1'b1 || overrun !== 1'b0) begin
            nerr++;
            $display("FAIL basic_flags: dv=%0b ovr=%0b required dv=1 ovr=0", data_valid, overrun);
        end
        ack_pulse();
    endtask

    task automatic test_ack_collision();
        logic [31:0] exp;
        send_frame(16'h0F1E, 16'h2D3C, 1'b1, 1'b0, 1'b0);
        exp = sb.pop_front();
        send_frame(16'h4B5A, 16'h6978, 1'b1, 1'b1, 1'b0);
        nvec++;
        if (sb.size() == 0) begin
            nerr++;
            $display("FAIL coll_sb: queue empty, required 1 entry");
        end else begin
            exp = sb.pop_front();
            if ({left_data, right_data} !== exp) begin
                nerr++;
                $display("FAIL coll_pair: got %h/%h required %h/%h", left_data, right_data, exp[31:16], exp[15:0]);
            end
        end
        nvec++;
        if (data_valid !== 1'b1 || overrun !== 1'b0) begin
            nerr++;
            $display("FAIL coll_flags: dv=%0b ovr=%0b required dv=1 ovr=0", data_valid, overrun);
        end
        ack_pulse();
    endtask

    task automatic test_frame_err();
        logic [31:0] exp;
        int          fe0;
        fe0 = fe_cnt;
        send_slot(1'b0, 16'hFFFF, 9);
        send_slot(1'b1, 16'h7777, 32);
        nvec++;
        if (fe_cnt - fe0 !== 1) begin
            nerr++;
            $display("FAIL fe_pulse: frame_err high cycles=%0d required=1", fe_cnt - fe0);
        end
        nvec++;
        if (data_valid !== 1'b0 || right_data !== 16'h6978) begin
            nerr++;
            $display("FAIL fe_discard: dv=%0b right=%h required dv=0 right=6978", data_valid, right_data);
        end
        send_frame(16'h1357, 16'h2468, 1'b1, 1'b0, 1'b0);
        nvec++;
        exp = sb.pop_front();
        if ({left_data, right_data} !== exp) begin
            nerr++;
            $display("FAIL fe_recover: got %h/%h required %h/%h", left_data, right_data, exp[31:16], exp[15:0]);
        end
        ack_pulse();
    endtask

    task automatic test_overrun();
        logic [31:0] exp;
        logic [15:0] lv[3];
        logic [15:0] rv[3];
        lv[0] = 16'h1111; rv[0] = 16'h8888;
        lv[1] = 16'h2222; rv[1] = 16'h9999;
        lv[2] = 16'h3333; rv[2] = 16'hAAAA;
        for (int k = 0; k < 3; k++) begin
            send_frame(lv[k], rv[k], 1'b1, 1'b0, 1'b0);
            nvec++;
            exp = sb.pop_front();
            if ({left_data, right_data} !== exp) begin
                nerr++;
                $display("FAIL ovr_pair%0d: got %h/%h required %h/%h", k, left_data, right_data, exp[31:16], exp[15:0]);
            end
            nvec++;
            if (overrun !== (k > 0)) begin
                nerr++;
                $display("FAIL ovr_flag%0d: overrun=%0b required=%0b", k, overrun, (k > 0));
            end
        end
        nvec++;
        if (data_valid !== 1'b1) begin
            nerr++;
            $display("FAIL ovr_dv: data_valid=%0b required=1", data_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp;
        send_slot(1'b0, 16'h5555, 32);
        for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        nvec++;
        if ({left_data, right_data, data_valid, frame_err, overrun} !== 35'd0) begin
            nerr++;
            $display("FAIL midrst_outputs: left=%h right=%h dv=%0b fe=%0b ovr=%0b required=all 0",
                     left_data, right_data, data_valid, frame_err, overrun);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 22; i++) send_bit(1'b1, 1'b1);
        nvec++;
        if (data_valid !== 1'b0) begin
            nerr++;
            $display("FAIL midrst_discard: data_valid=%0b required=0", data_valid);
        end
        send_frame(16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 1'b0);
        nvec++;
        exp = sb.pop_front();
        if ({left_data, right_data, overrun} !== {exp, 1'b0}) begin
            nerr++;
            $display("FAIL midrst_pair: got %h/%h ovr=%0b required %h/%h ovr=0",
                     left_data, right_data, overrun, exp[31:16], exp[15:0]);
        end
        ack_pulse();
    endtask

`ifdef AUDIO_RX_PEAK_EN
    task automatic test_peak();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        nvec++;
        if (peak_level !== 15'h0) begin
            nerr++;
            $display("FAIL peak_reset: peak=%h required=0000", peak_level);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        send_frame(16'h8000, 16'h0100, 1'b1, 1'b0, 1'b0);
        void'(sb.pop_front());
        nvec++;
        if (peak_level !== 15'h7FFF) begin
            nerr++;
            $display("FAIL peak_sat: peak=%h required=7fff", peak_level);
        end
        ack_pulse();
        peak_clr = 1'b1;
        @(negedge clk);
        peak_clr = 1'b0;
        nvec++;
        if (peak_level !== 15'h0) begin
            nerr++;
            $display("FAIL peak_clr: peak=%h required=0000", peak_level);
        end
        send_frame(16'h0010, 16'hFFF0, 1'b1, 1'b0, 1'b1);
        void'(sb.pop_front());
        nvec++;
        if (peak_level !== 15'h0010) begin
            nerr++;
            $display("FAIL peak_clr_pair: peak=%h required=0010", peak_level);
        end
        ack_pulse();
    endtask
`endif

    initial begin
        nvec   = 0;
        nerr   = 0;
        fe_cnt = 0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_ack_collision();
        test_frame_err();
        test_overrun();
        test_reset_mid();
`ifdef AUDIO_RX_PEAK_EN
        test_peak();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
